// File: rtl/trdb_packet_decoder.sv
// -----------------------------------------------------------------------------
// trdb_packet_decoder
//
// Receive side of the trace packet stream. Takes one decoded packet per
// pkt_valid_i/pkt_ready_o handshake and turns it into:
//   - a stream of branch outcomes, one taken/not-taken bit per handshake, and
//   - a reconstructed absolute address. Differential packets are added to the
//     last address; full packets are sign-extended from keep_bits.
//
// Encodings on the packet side:
//   pkt_format_i    : 0 F_BRANCH_FULL, 1 F_BRANCH_DIFF, 2 F_ADDR_ONLY, 3 F_SYNC
//   pkt_subformat_i : 0 SF_START, 1 SF_EXCEPTION, 2 SF_CONTEXT, 3 SF_UNDEF
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   pkt_valid_i/ready_o   packet handshake (ready only while idle)
//   pkt_format_i          packet format
//   pkt_subformat_i       sync subformat
//   pkt_addr_i            address field, low keep_bits bits significant
//   pkt_keep_bits_i       number of significant address bits
//   pkt_branch_cnt_i      branches in the map, 0 means a full map
//   pkt_branch_map_i      bit 0 = oldest branch, 1 = taken
//   branch_valid_o/ready_i, branch_taken_o   branch outcome stream
//   addr_valid_o/ready_i, addr_o, addr_sync_o  reconstructed address
//   synced_o              a sync packet has been seen since reset
//   drop_o                one-cycle pulse when a packet is discarded
//
// Optional build macro TRDB_DECODER_STATS_EN adds stat_pkts_o / stat_drops_o,
// saturating 32-bit counters of accepted packets and drop pulses.
// -----------------------------------------------------------------------------
module trdb_packet_decoder #(
   parameter int XLEN     = 32,
   parameter int BMAP_LEN = 31,
   parameter int CNT_W    = 5,
   localparam int KB_W    = $clog2(XLEN) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                pkt_valid_i,
   output logic                pkt_ready_o,
   input  logic [1:0]          pkt_format_i,
   input  logic [1:0]          pkt_subformat_i,
   input  logic [XLEN-1:0]     pkt_addr_i,
   input  logic [KB_W-1:0]     pkt_keep_bits_i,
   input  logic [CNT_W-1:0]    pkt_branch_cnt_i,
   input  logic [BMAP_LEN-1:0] pkt_branch_map_i,
   output logic                branch_valid_o,
   input  logic                branch_ready_i,
   output logic                branch_taken_o,
   output logic                addr_valid_o,
   input  logic                addr_ready_i,
   output logic [XLEN-1:0]     addr_o,
   output logic                addr_sync_o,
   output logic                synced_o,
   output logic                drop_o
`ifdef TRDB_DECODER_STATS_EN
   ,
   output logic [31:0]         stat_pkts_o,
   output logic [31:0]         stat_drops_o
`endif
);

   localparam logic [1:0] F_BRANCH_FULL = 2'd0;
   localparam logic [1:0] F_BRANCH_DIFF = 2'd1;
   localparam logic [1:0] F_ADDR_ONLY   = 2'd2;
   localparam logic [1:0] F_SYNC        = 2'd3;

   localparam logic [1:0] SF_START      = 2'd0;
   localparam logic [1:0] SF_EXCEPTION  = 2'd1;

   localparam logic [CNT_W-1:0] BMAP_N = CNT_W'(BMAP_LEN);
   localparam logic [KB_W-1:0]  XLEN_K = KB_W'(XLEN);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BRANCH = 2'd1,
      S_ADDR   = 2'd2
   } state_e;

   state_e state, state_nx;

   // Registered datapath
   logic [BMAP_LEN-1:0] shreg;
   logic [CNT_W-1:0]    cnt_q;
   logic                has_addr_q;   // branch packet is followed by an address
   logic [XLEN-1:0]     addr_q;
   logic                sync_q;
   logic [XLEN-1:0]     last_addr;
   logic                synced_q;
   logic                drop_q;

   // Packet decode
   logic                accept;
   logic                is_sync_addr;
   logic                is_drop;
   logic                is_branch;
   logic                pkt_has_addr;
   logic                pkt_diff;
   logic [CNT_W-1:0]    n_cnt;
   logic [KB_W-1:0]     sh;
   logic [XLEN-1:0]     shl;
   logic [XLEN-1:0]     ext;
   logic [XLEN-1:0]     new_addr;

   assign accept = pkt_valid_i & (state == S_IDLE);

   // Classify the packet. Before the first sync only address-carrying sync
   // packets mean anything; everything non-sync is thrown away, and the
   // context/undefined sync subformats are consumed silently in any state.
   always_comb begin
      is_sync_addr = 1'b0;
      is_drop      = 1'b0;
      is_branch    = 1'b0;
      pkt_has_addr = 1'b0;
      pkt_diff     = 1'b0;
      if (pkt_format_i == F_SYNC) begin
         if (pkt_subformat_i == SF_START || pkt_subformat_i == SF_EXCEPTION)
            is_sync_addr = 1'b1;
      end else if (!synced_q) begin
         is_drop = 1'b1;
      end else begin
         case (pkt_format_i)
            F_ADDR_ONLY: pkt_has_addr = 1'b1;
            F_BRANCH_FULL: begin
               is_branch    = 1'b1;
               pkt_has_addr = (pkt_branch_cnt_i != '0);
            end
            F_BRANCH_DIFF: begin
               is_branch    = 1'b1;
               pkt_has_addr = (pkt_branch_cnt_i != '0);
               pkt_diff     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Zero means a full map; anything beyond the map width is clamped.
   always_comb begin
      if (pkt_branch_cnt_i == '0 || pkt_branch_cnt_i > BMAP_N)
         n_cnt = BMAP_N;
      else
         n_cnt = pkt_branch_cnt_i;
   end

   // Sign extension from bit k-1: push the significant field to the top and
   // arithmetic-shift it back down. k==0 and k>=XLEN pass the field through.
   always_comb begin
      sh  = '0;
      shl = '0;
      if (pkt_keep_bits_i == '0 || pkt_keep_bits_i >= XLEN_K) begin
         ext = pkt_addr_i;
      end else begin
         sh  = XLEN_K - pkt_keep_bits_i;
         shl = pkt_addr_i << sh;
         ext = $signed(shl) >>> sh;
      end
   end

   // Differential addresses wrap modulo 2**XLEN.
   assign new_addr = pkt_diff ? (last_addr + ext) : ext;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_branch)
                  state_nx = S_BRANCH;
               else if (is_sync_addr || pkt_has_addr)
                  state_nx = S_ADDR;
            end
         end
         S_BRANCH: begin
            if (branch_ready_i && cnt_q == CNT_W'(1))
               state_nx = has_addr_q ? S_ADDR : S_IDLE;
         end
         S_ADDR: begin
            if (addr_ready_i) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs. Data outputs are forced to zero outside their valid state so
   // stale map bits or addresses never leak onto the sinks.
   always_comb begin
      pkt_ready_o    = (state == S_IDLE);
      branch_valid_o = (state == S_BRANCH);
      branch_taken_o = (state == S_BRANCH) & shreg[0];
      addr_valid_o   = (state == S_ADDR);
      addr_o         = (state == S_ADDR) ? addr_q : '0;
      addr_sync_o    = (state == S_ADDR) & sync_q;
      synced_o       = synced_q;
      drop_o         = drop_q;
   end

   // Datapath. last_addr follows every accepted address-carrying packet at
   // acceptance time, so it already reflects a packet whose branches are
   // still being drained.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg      <= '0;
         cnt_q      <= '0;
         has_addr_q <= 1'b0;
         addr_q     <= '0;
         sync_q     <= 1'b0;
         last_addr  <= '0;
         synced_q   <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         drop_q <= accept & is_drop;
         if (accept) begin
            if (is_sync_addr) begin
               addr_q    <= pkt_addr_i;
               sync_q    <= 1'b1;
               last_addr <= pkt_addr_i;
               synced_q  <= 1'b1;
            end else if (pkt_has_addr) begin
               addr_q    <= new_addr;
               sync_q    <= 1'b0;
               last_addr <= new_addr;
            end
            if (is_branch) begin
               shreg      <= pkt_branch_map_i;
               cnt_q      <= n_cnt;
               has_addr_q <= pkt_has_addr;
            end
         end else if (state == S_BRANCH && branch_ready_i) begin
            shreg <= shreg >> 1;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

`ifdef TRDB_DECODER_STATS_EN
   // Saturating statistics; the drop counter steps on the same edge that
   // raises drop_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_pkts_o  <= '0;
         stat_drops_o <= '0;
      end else begin
         if (accept && stat_pkts_o != '1)
            stat_pkts_o <= stat_pkts_o + 32'd1;
         if (accept && is_drop && stat_drops_o != '1)
            stat_drops_o <= stat_drops_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_trdb_packet_decoder.sv
module tb_trdb_packet_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pkt_valid = 1'b0;
   logic        pkt_ready;
   logic [1:0]  pkt_format = '0;
   logic [1:0]  pkt_subformat = '0;
   logic [31:0] pkt_addr = '0;
   logic [5:0]  pkt_keep_bits = '0;
   logic [4:0]  pkt_branch_cnt = '0;
   logic [30:0] pkt_branch_map = '0;
   logic        branch_valid;
   logic        branch_ready = 1'b1;
   logic        branch_taken;
   logic        addr_valid;
   logic        addr_ready = 1'b1;
   logic [31:0] addr;
   logic        addr_sync;
   logic        synced;
   logic        drop;
`ifdef TRDB_DECODER_STATS_EN
   logic [31:0] stat_pkts;
   logic [31:0] stat_drops;
`endif

   trdb_packet_decoder dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .pkt_valid_i      (pkt_valid),
      .pkt_ready_o      (pkt_ready),
      .pkt_format_i     (pkt_format),
      .pkt_subformat_i  (pkt_subformat),
      .pkt_addr_i       (pkt_addr),
      .pkt_keep_bits_i  (pkt_keep_bits),
      .pkt_branch_cnt_i (pkt_branch_cnt),
      .pkt_branch_map_i (pkt_branch_map),
      .branch_valid_o   (branch_valid),
      .branch_ready_i   (branch_ready),
      .branch_taken_o   (branch_taken),
      .addr_valid_o     (addr_valid),
      .addr_ready_i     (addr_ready),
      .addr_o           (addr),
      .addr_sync_o      (addr_sync),
      .synced_o         (synced),
      .drop_o           (drop)
`ifdef TRDB_DECODER_STATS_EN
      ,
      .stat_pkts_o      (stat_pkts),
      .stat_drops_o     (stat_drops)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  fmt;
      logic [1:0]  sf;
      logic [31:0] a;
      logic [5:0]  k;
      logic [4:0]  cnt;
      logic [30:0] map;
      int          exp_n;
      logic [30:0] exp_map;
      bit          exp_av;
      logic [31:0] exp_addr;
      bit          exp_sync;
      bit          exp_drop;
      bit          exp_synced;
      int          stall_at;
      int          addr_stall;
   } vec_t;

   function automatic vec_t mk(logic [1:0] fmt, logic [1:0] sf, logic [31:0] a,
                               logic [5:0] k, logic [4:0] cnt, logic [30:0] map,
                               int exp_n, logic [30:0] exp_map, bit exp_av,
                               logic [31:0] exp_addr, bit exp_sync, bit exp_drop,
                               bit exp_synced, int stall_at, int addr_stall);
      vec_t v;
      v.fmt = fmt; v.sf = sf; v.a = a; v.k = k; v.cnt = cnt; v.map = map;
      v.exp_n = exp_n; v.exp_map = exp_map; v.exp_av = exp_av;
      v.exp_addr = exp_addr; v.exp_sync = exp_sync; v.exp_drop = exp_drop;
      v.exp_synced = exp_synced; v.stall_at = stall_at; v.addr_stall = addr_stall;
      return v;
   endfunction

   // Send one packet and follow its outputs cycle by cycle. Inputs change and
   // outputs are sampled on the falling edge.
   task automatic run_vec(input int idx, input vec_t v);
      int w;
      @(negedge clk);
      pkt_format = v.fmt; pkt_subformat = v.sf; pkt_addr = v.a;
      pkt_keep_bits = v.k; pkt_branch_cnt = v.cnt; pkt_branch_map = v.map;
      pkt_valid = 1'b1; branch_ready = 1'b1; addr_ready = 1'b1;
      w = 0;
      while (!pkt_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("v%0d_pkt_ready", idx), pkt_ready, 1);
      @(negedge clk);
      pkt_valid = 1'b0;
      chk($sformatf("v%0d_drop", idx), drop, v.exp_drop);
      for (int i = 0; i < v.exp_n; i++) begin
         if (i == v.stall_at) begin
            branch_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk($sformatf("v%0d_stall_valid%0d", idx, i), branch_valid, 1);
               chk($sformatf("v%0d_stall_taken%0d", idx, i), branch_taken, v.exp_map[i]);
            end
            branch_ready = 1'b1;
         end
         chk($sformatf("v%0d_bvalid%0d", idx, i), branch_valid, 1);
         chk($sformatf("v%0d_taken%0d", idx, i), branch_taken, v.exp_map[i]);
         chk($sformatf("v%0d_avalid_in_branch%0d", idx, i), addr_valid, 0);
         @(negedge clk);
      end
      if (v.exp_av) begin
         for (int s = 0; s < v.addr_stall; s++) begin
            addr_ready = 1'b0;
            chk($sformatf("v%0d_astall_valid%0d", idx, s), addr_valid, 1);
            chk($sformatf("v%0d_astall_addr%0d", idx, s), addr, v.exp_addr);
            @(negedge clk);
         end
         addr_ready = 1'b1;
         chk($sformatf("v%0d_avalid", idx), addr_valid, 1);
         chk($sformatf("v%0d_bvalid_in_addr", idx), branch_valid, 0);
         chk($sformatf("v%0d_addr", idx), addr, v.exp_addr);
         chk($sformatf("v%0d_addr_sync", idx), addr_sync, v.exp_sync);
         @(negedge clk);
      end
      chk($sformatf("v%0d_idle_ready", idx), pkt_ready, 1);
      chk($sformatf("v%0d_idle_bvalid", idx), branch_valid, 0);
      chk($sformatf("v%0d_idle_avalid", idx), addr_valid, 0);
      chk($sformatf("v%0d_synced", idx), synced, v.exp_synced);
      @(negedge clk);
      chk($sformatf("v%0d_drop_clear", idx), drop, 0);
   endtask

   localparam int NV = 13;
   vec_t vecs[NV];

   initial begin
      // fmt, sf, addr, k, cnt, map, exp_n, exp_map, av, exp_addr, sync, drop, synced, stall, astall
      vecs[0]  = mk(2'd2, 2'd0, 32'h0000_0100, 6'd12, 5'd0, 31'h0,        0, 31'h0,        0, 32'h0,         0, 1, 0, -1, 0);
      vecs[1]  = mk(2'd3, 2'd0, 32'h8000_0000, 6'd0,  5'd0, 31'h0,        0, 31'h0,        1, 32'h8000_0000, 1, 0, 1, -1, 0);
      vecs[2]  = mk(2'd3, 2'd0, 32'h0000_1000, 6'd0,  5'd0, 31'h0,        0, 31'h0,        1, 32'h0000_1000, 1, 0, 1, -1, 1);
      vecs[3]  = mk(2'd1, 2'd0, 32'h0000_0FF0, 6'd5,  5'd3, 31'b101,      3, 31'b101,      1, 32'h0000_0FF0, 0, 0, 1, -1, 0);
      vecs[4]  = mk(2'd0, 2'd0, 32'h0,         6'd0,  5'd0, 31'h7FFFFFFF, 31, 31'h7FFFFFFF, 0, 32'h0,        0, 0, 1, 10, 0);
      vecs[5]  = mk(2'd3, 2'd1, 32'hFFFF_FFF0, 6'd3,  5'd0, 31'h0,        0, 31'h0,        1, 32'hFFFF_FFF0, 1, 0, 1, -1, 0);
      vecs[6]  = mk(2'd1, 2'd0, 32'h0000_0020, 6'd7,  5'd1, 31'h0,        1, 31'h0,        1, 32'h0000_0010, 0, 0, 1, -1, 0);
      vecs[7]  = mk(2'd2, 2'd0, 32'h0000_07FC, 6'd11, 5'd0, 31'h0,        0, 31'h0,        1, 32'hFFFF_FFFC, 0, 0, 1, -1, 3);
      vecs[8]  = mk(2'd3, 2'd2, 32'hDEAD_0000, 6'd0,  5'd0, 31'h0,        0, 31'h0,        0, 32'h0,         0, 0, 1, -1, 0);
      vecs[9]  = mk(2'd0, 2'd0, 32'h1234_5678, 6'd32, 5'd2, 31'b10,       2, 31'b10,       1, 32'h1234_5678, 0, 0, 1, -1, 0);
      vecs[10] = mk(2'd1, 2'd0, 32'h0000_ABCD, 6'd9,  5'd0, 31'h55555555, 31, 31'h55555555, 0, 32'h0,        0, 0, 1, -1, 0);
      vecs[11] = mk(2'd1, 2'd0, 32'h0000_0008, 6'd0,  5'd2, 31'b11,       2, 31'b11,       1, 32'h1234_5680, 0, 0, 1, -1, 0);
      vecs[12] = mk(2'd2, 2'd0, 32'h8000_0001, 6'd1,  5'd0, 31'h0,        0, 31'h0,        1, 32'hFFFF_FFFF, 0, 0, 1, -1, 0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pkt_ready", pkt_ready, 1);
      chk("rst_bvalid", branch_valid, 0);
      chk("rst_avalid", addr_valid, 0);
      chk("rst_addr", addr, 0);
      chk("rst_synced", synced, 0);
      chk("rst_drop", drop, 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

`ifdef TRDB_DECODER_STATS_EN
      chk("stat_pkts", stat_pkts, NV);
      chk("stat_drops", stat_drops, 1);
`endif

      // Reset in the middle of a branch stream
      @(negedge clk);
      pkt_format = 2'd0; pkt_subformat = 2'd0; pkt_branch_cnt = 5'd0;
      pkt_branch_map = 31'h7FFFFFFF; pkt_valid = 1'b1;
      @(negedge clk);
      pkt_valid = 1'b0;
      branch_ready = 1'b0;
      chk("midrst_in_branch", branch_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      branch_ready = 1'b1;
      chk("midrst_pkt_ready", pkt_ready, 1);
      chk("midrst_bvalid", branch_valid, 0);
      chk("midrst_taken", branch_taken, 0);
      chk("midrst_avalid", addr_valid, 0);
      chk("midrst_synced", synced, 0);
`ifdef TRDB_DECODER_STATS_EN
      chk("midrst_stat_pkts", stat_pkts, 0);
      chk("midrst_stat_drops", stat_drops, 0);
`endif
      // Sync state was lost, so an address-only packet is dropped again
      run_vec(100, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
